// File: rtl/avg_pool_window_generator.sv
// Streams a pooled feature map out of BRAM in raster order and emits every unpadded 3x3 window
// through a 2-entry first-word-fall-through FIFO with valid/ready backpressure.
module avg_pool_window_generator #(
  parameter int number_datawidth             = 16,
  parameter int output_map_address_datawidth = 11,
  parameter int STATE_DATAWIDTH              = 4,
  parameter int AVG1_STATE                   = 3,
  parameter int AVG2_STATE                   = 6,
  parameter int AVG3_STATE                   = 9,
  parameter int AVG1_OUTPUT_SIZE             = 40,
  parameter int AVG2_OUTPUT_SIZE             = 18,
  parameter int AVG3_OUTPUT_SIZE             = 7,
  parameter int MAX_MAP_SIZE                 = 40
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [STATE_DATAWIDTH-1:0]              state,
  input  logic [number_datawidth-1:0]             BRAM_Win_In,
  output logic                                    rd_ena,
  output logic [output_map_address_datawidth-1:0] BRAM_Win_In_Address,
  output logic                                    win_valid,
  input  logic                                    win_ready,
  output logic [9*number_datawidth-1:0]           window,
  output logic                                    busy,
  output logic                                    done,
  output logic [1:0]                              dbg_fsm_state
);

  localparam int DW = number_datawidth;
  localparam int AW = output_map_address_datawidth;
  localparam int CW = $clog2(MAX_MAP_SIZE + 1);

  // Handshake: a window transfers on a rising clk edge where win_valid && win_ready; while
  // win_valid is high and win_ready low, window holds its value and nothing is dropped.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [CW-1:0]   n_q, n_sel;
  logic [AW-1:0]   last_addr_q, last_sel;
  logic [AW-1:0]   addr_q;
  logic            rd_pend_q;
  logic [CW-1:0]   row_q, col_q;
  logic [9*DW-1:0] win_q, win_d;
  logic [DW-1:0]   line_a_q [MAX_MAP_SIZE];
  logic [DW-1:0]   line_b_q [MAX_MAP_SIZE];
  logic [DW-1:0]   new_col  [3];
  logic [9*DW-1:0] fifo_mem_q [2];
  logic            fifo_rd_q, fifo_wr_q;
  logic [1:0]      fifo_cnt_q;
  logic            push, pop;

  always_comb begin
    n_sel    = CW'(AVG1_OUTPUT_SIZE);
    last_sel = AW'(AVG1_OUTPUT_SIZE * AVG1_OUTPUT_SIZE - 1);
    if (state == STATE_DATAWIDTH'(AVG2_STATE)) begin
      n_sel    = CW'(AVG2_OUTPUT_SIZE);
      last_sel = AW'(AVG2_OUTPUT_SIZE * AVG2_OUTPUT_SIZE - 1);
    end else if (state == STATE_DATAWIDTH'(AVG3_STATE)) begin
      n_sel    = CW'(AVG3_OUTPUT_SIZE);
      last_sel = AW'(AVG3_OUTPUT_SIZE * AVG3_OUTPUT_SIZE - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (start) fsm_d = S_FETCH;
      S_FETCH: if (rd_ena && addr_q == last_addr_q) fsm_d = S_DRAIN;
      S_DRAIN: if (fifo_cnt_q == 2'd0 && !rd_pend_q) fsm_d = S_DONE;
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // A read is only issued when a FIFO slot is guaranteed for the pixel it returns.
  always_comb begin
    rd_ena = (fsm_q == S_FETCH) &&
             (fifo_cnt_q == 2'd0 || (fifo_cnt_q == 2'd1 && win_ready));
    busy   = (fsm_q == S_FETCH) || (fsm_q == S_DRAIN);
    done   = (fsm_q == S_DONE);
  end

  always_comb begin
    win_d      = win_q;
    new_col[0] = line_a_q[col_q];
    new_col[1] = line_b_q[col_q];
    new_col[2] = BRAM_Win_In;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_d[DW*(3*r+c) +: DW] = win_q[DW*(3*r+c+1) +: DW];
      end
      win_d[DW*(3*r+2) +: DW] = new_col[r];
    end
  end

  assign push = rd_pend_q && (row_q >= CW'(2)) && (col_q >= CW'(2));
  assign pop  = (fifo_cnt_q != 2'd0) && win_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      last_addr_q <= '0;
      addr_q      <= '0;
      rd_pend_q   <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (fsm_q == S_IDLE && start) begin
        n_q         <= n_sel;
        last_addr_q <= last_sel;
        addr_q      <= '0;
        row_q       <= '0;
        col_q       <= '0;
      end
      if (rd_ena) addr_q <= addr_q + AW'(1);
      rd_pend_q <= rd_ena;
      if (rd_pend_q) begin
        win_q <= win_d;
        if (col_q == n_q - CW'(1)) begin
          col_q <= '0;
          row_q <= row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (push) fifo_wr_q <= ~fifo_wr_q;
      if (pop)  fifo_rd_q <= ~fifo_rd_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage arrays carry no reset: their contents are overwritten before they are ever observed.
  always_ff @(posedge clk) begin
    if (rd_pend_q) begin
      line_b_q[col_q] <= BRAM_Win_In;
      line_a_q[col_q] <= line_b_q[col_q];
    end
    if (push) fifo_mem_q[fifo_wr_q] <= win_d;
  end

  assign win_valid           = (fifo_cnt_q != 2'd0);
  assign window              = win_valid ? fifo_mem_q[fifo_rd_q] : '0;
  assign BRAM_Win_In_Address = addr_q;
  assign dbg_fsm_state       = fsm_q;

endmodule

// File: tb/tb_avg_pool_window_generator.sv
// Bench for avg_pool_window_generator: BRAM model holding 16'h1000+addr, scoreboard of expected
// windows, table of map runs plus hand sequences for reset and literal window checks.
module tb_avg_pool_window_generator;

  localparam int WW = 144;

  logic          clk = 1'b0;
  logic          reset, start, win_ready;
  logic [3:0]    state;
  logic [15:0]   bram_q = 16'h0;
  logic          rd_ena, win_valid, busy, done;
  logic [10:0]   addr;
  logic [WW-1:0] window;
  logic [1:0]    dbg_fsm_state;

  avg_pool_window_generator dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .state               (state),
    .BRAM_Win_In         (bram_q),
    .rd_ena              (rd_ena),
    .BRAM_Win_In_Address (addr),
    .win_valid           (win_valid),
    .win_ready           (win_ready),
    .window              (window),
    .busy                (busy),
    .done                (done),
    .dbg_fsm_state       (dbg_fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_ena) bram_q <= 16'h1000 + {5'd0, addr};
  end

  logic [WW-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int last_rd_addr = -1;
  bit ovf_seen = 0;
  bit prev_stall = 0;
  logic [WW-1:0] prev_win, first_win, last_win, win16;

  typedef int list9_t[9];

  typedef struct {
    logic [3:0] code;
    int         n;
    bit         rand_ready;
    bit         restart;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WW-1:0] from_list(input list9_t l);
    logic [WW-1:0] w;
    for (int i = 0; i < 9; i++) w[16*i +: 16] = 16'h1000 + 16'(l[i]);
    return w;
  endfunction

  function automatic logic [WW-1:0] make_win(input int n, input int r, input int c);
    logic [WW-1:0] w;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[16*(3*rr+cc) +: 16] = 16'h1000 + 16'((r + rr) * n + (c + cc));
    return w;
  endfunction

  task automatic push_expected(input int n);
    exp_q.delete();
    for (int r = 0; r < n - 2; r++)
      for (int c = 0; c < n - 2; c++)
        exp_q.push_back(make_win(n, r, c));
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", WW'(win_valid), WW'(1));
        check("stall_window", window, prev_win);
      end
      if (dut.fifo_cnt_q == 2'd2) check("rd_ena_when_full", WW'(rd_ena), WW'(0));
      if (dut.fifo_cnt_q == 2'd3) ovf_seen = 1;
      if (rd_ena) last_rd_addr = int'(addr);
      if (done) done_cnt++;
      if (win_valid && win_ready) begin
        if (win_cnt == 0) first_win = window;
        if (win_cnt == 16) win16 = window;
        last_win = window;
        win_cnt++;
        if (exp_q.size() == 0) check("extra_window", window, '0);
        else check("window", window, exp_q.pop_front());
      end
      prev_stall = win_valid && !win_ready;
      prev_win   = window;
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [3:0] s);
    @(posedge clk); #1;
    state = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    state = ~s;
  endtask

  task automatic run_map(input logic [3:0] s, input int n, input bit rand_ready, input bit restart);
    bit got_done;
    win_cnt      = 0;
    done_cnt     = 0;
    ovf_seen     = 0;
    last_rd_addr = -1;
    push_expected(n);
    win_ready = 1'b1;
    pulse_start(s);
    check("busy_after_start", WW'(busy), WW'(1));
    got_done = 0;
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (restart) start = (cyc == 20);
      @(posedge clk); #1;
      if (done) got_done = 1;
    end
    start = 1'b0;
    check("done_seen", WW'(got_done), WW'(1));
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("window_count", WW'(win_cnt), WW'((n - 2) * (n - 2)));
    check("done_pulses", WW'(done_cnt), WW'(1));
    check("scoreboard_empty", WW'(exp_q.size()), WW'(0));
    check("busy_after_done", WW'(busy), WW'(0));
    check("fifo_overflow", WW'(ovf_seen), WW'(0));
    check("last_read_addr", WW'(last_rd_addr), WW'(n * n - 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_ena"},    WW'(rd_ena),    WW'(0));
    check({tag, "_win_valid"}, WW'(win_valid), WW'(0));
    check({tag, "_busy"},      WW'(busy),      WW'(0));
    check({tag, "_done"},      WW'(done),      WW'(0));
    check({tag, "_address"},   WW'(addr),      WW'(0));
    check({tag, "_window"},    window,         '0);
  endtask

  list9_t t1_first = '{0, 1, 2, 7, 8, 9, 14, 15, 16};
  list9_t t1_last  = '{32, 33, 34, 39, 40, 41, 46, 47, 48};
  list9_t t3_w16   = '{18, 19, 20, 36, 37, 38, 54, 55, 56};

  initial begin
    reset = 1'b1; start = 1'b0; win_ready = 1'b0; state = 4'd0;
    vecs[0] = '{code: 4'd9, n: 7,  rand_ready: 1'b1, restart: 1'b0};
    vecs[1] = '{code: 4'd6, n: 18, rand_ready: 1'b0, restart: 1'b0};
    vecs[2] = '{code: 4'd4, n: 40, rand_ready: 1'b0, restart: 1'b0};
    vecs[3] = '{code: 4'd3, n: 40, rand_ready: 1'b1, restart: 1'b0};
    vecs[4] = '{code: 4'd9, n: 7,  rand_ready: 1'b0, restart: 1'b1};
    vecs[5] = '{code: 4'd0, n: 40, rand_ready: 1'b0, restart: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_fsm", WW'(dbg_fsm_state), WW'(0));
    reset = 1'b0;

    // T1: literal first and last window of the 7x7 map
    run_map(4'd9, 7, 1'b0, 1'b0);
    check("t1_first", first_win, from_list(t1_first));
    check("t1_last",  last_win,  from_list(t1_last));

    // T3: literal window at row 1, column 0 of the 18x18 map
    run_map(4'd6, 18, 1'b0, 1'b0);
    check("t3_window16", win16, from_list(t3_w16));

    foreach (vecs[i]) run_map(vecs[i].code, vecs[i].n, vecs[i].rand_ready, vecs[i].restart);

    // T5: reset in the middle of a map, then the same map again from scratch
    win_cnt = 0;
    push_expected(7);
    win_ready = 1'b1;
    pulse_start(4'd9);
    for (int cyc = 0; cyc < 5000 && win_cnt < 10; cyc++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_10", WW'(win_cnt >= 10), WW'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("t5_reset");
    check("t5_fifo_empty", WW'(dut.fifo_cnt_q), WW'(0));
    reset = 1'b0;
    run_map(4'd9, 7, 1'b0, 1'b0);
    check("t5_first", first_win, from_list(t1_first));
    check("t5_last",  last_win,  from_list(t1_last));

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
